riscv_div_unit: RTL and testbench

- Multi-cycle RV32M divide/remainder unit: DIV, DIVU, REM, REMU.
- Restoring algorithm, one quotient bit per cycle; uses the same shared subtract datapath in both signed and unsigned modes.
- Sits beside the ALU in EX. The pipeline stalls on busy_o and captures result_o on valid_o.

---
 rtl/riscv_div_pkg.sv | 20 ++
 rtl/riscv_div_step.sv | 32 +++
 rtl/riscv_div_unit.sv | 167 ++++++++++++++++
 tb/tb_riscv_div_unit.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/riscv_div_pkg.sv
// Shared definitions for the RV32M divide/remainder unit:
// operation encodings, FSM state type and default operand width.
`timescale 1ns/1ps
package riscv_div_pkg;

  localparam int DIV_XLEN_DEFAULT = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_PREP = 2'b01,
    DIV_CALC = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/riscv_div_step.sv
// One restoring-division step: shift {rem,quo} left by one, trial-subtract
// the divisor from the widened remainder and keep the difference when no
// borrow occurs.
//
// The subtract is XLEN+1 bits wide. Because the incoming remainder is always
// below the divisor, a non-negative difference never reaches bit XLEN, so
// the top bit of the XLEN+1-bit result is exactly the borrow.
`timescale 1ns/1ps
module riscv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          borrow;

  // Shift, trial-subtract, and restore on borrow.
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    trial    = shifted - {1'b0, divisor};
    borrow   = trial[XLEN];
    rem_next = borrow ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], ~borrow};
  end

endmodule

// File: rtl/riscv_div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit (restoring, one quotient bit per
// cycle). FSM: IDLE -> PREP -> CALC (XLEN cycles) -> DONE -> IDLE.
// Signed operations divide magnitudes and fix the signs on the way into DONE.
// Divide-by-zero and signed overflow results are fixed in PREP.
//
// Optional macro RISCV_DIV_FAST_SPECIAL_EN: special cases, and |a| < |b|,
// skip CALC and go straight from PREP to DONE.
`timescale 1ns/1ps
module riscv_div_unit
  import riscv_div_pkg::*;
#(
  parameter int XLEN = DIV_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = (XLEN > 2) ? $clog2(XLEN) : 1;

  div_state_e       state;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  div_q;
  logic [CNT_W-1:0] cnt;
  logic             q_neg;
  logic             r_neg;
  logic             spec_q;
  logic [XLEN-1:0]  spec_res_q;

  logic             signed_op;
  logic             is_rem;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  a_abs;
  logic [XLEN-1:0]  b_abs;
  logic             special;
  logic [XLEN-1:0]  special_res;
  logic [XLEN-1:0]  rem_nxt;
  logic [XLEN-1:0]  quo_nxt;
`ifdef RISCV_DIV_FAST_SPECIAL_EN
  logic             small;
`endif

  // Two's-complement sign fix-up of the magnitude result, then op select.
  function automatic logic [XLEN-1:0] finalize(input logic [XLEN-1:0] quo,
                                               input logic [XLEN-1:0] rem,
                                               input logic            sel_rem,
                                               input logic            neg_q,
                                               input logic            neg_r);
    logic [XLEN-1:0] res;
    if (sel_rem) res = neg_r ? (~rem + 1'b1) : rem;
    else         res = neg_q ? (~quo + 1'b1) : quo;
    return res;
  endfunction

  assign busy_o = (state != DIV_IDLE);

  // Operand magnitudes and special-case detection from latched operands.
  always_comb begin
    signed_op = ~op_q[0];
    is_rem    = op_q[1];
    a_neg     = signed_op & a_q[XLEN-1];
    b_neg     = signed_op & b_q[XLEN-1];
    a_abs     = a_neg ? (~a_q + 1'b1) : a_q;
    b_abs     = b_neg ? (~b_q + 1'b1) : b_q;
    special     = 1'b0;
    special_res = '0;
    if (b_q == '0) begin
      special     = 1'b1;
      special_res = is_rem ? a_q : '1;
    end else if (signed_op && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1)) begin
      special     = 1'b1;
      special_res = is_rem ? '0 : a_q;
    end
`ifdef RISCV_DIV_FAST_SPECIAL_EN
    small = (a_abs < b_abs);
`endif
  end

  riscv_div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (div_q),
    .rem_next (rem_nxt),
    .quo_next (quo_nxt)
  );

  // FSM, iteration state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= DIV_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      cnt        <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      valid_o    <= 1'b0;
      result_o   <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          valid_o <= 1'b0;
          if (start_i) begin
            op_q  <= op_i;
            a_q   <= a_i;
            b_q   <= b_i;
            state <= DIV_PREP;
          end
        end
        DIV_PREP: begin
          q_neg      <= a_neg ^ b_neg;
          r_neg      <= a_neg;
          quo_q      <= a_abs;
          rem_q      <= '0;
          div_q      <= b_abs;
          cnt        <= CNT_W'(XLEN - 1);
          spec_q     <= special;
          spec_res_q <= special_res;
`ifdef RISCV_DIV_FAST_SPECIAL_EN
          if (special || small) begin
            state    <= DIV_DONE;
            valid_o  <= 1'b1;
            result_o <= special ? special_res : (is_rem ? a_q : '0);
          end else begin
            state <= DIV_CALC;
          end
`else
          state <= DIV_CALC;
`endif
        end
        DIV_CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state    <= DIV_DONE;
            valid_o  <= 1'b1;
            result_o <= spec_q ? spec_res_q
                                : finalize(quo_nxt, rem_nxt, is_rem, q_neg, r_neg);
          end
        end
        DIV_DONE: begin
          valid_o <= 1'b0;
          state   <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed testbench for riscv_div_unit (XLEN=32). Honours
// RISCV_DIV_FAST_SPECIAL_EN when choosing expected latencies.
`timescale 1ns/1ps
module tb_riscv_div_unit;
  import riscv_div_pkg::*;

`ifdef RISCV_DIV_FAST_SPECIAL_EN
  localparam int LAT_SP = 2;
`else
  localparam int LAT_SP = 34;
`endif
  localparam int LAT_FULL = 34;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;

  riscv_div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Start one operation, wait for valid_o, check latency/result/busy and the
  // cycle after DONE. Returns in the cycle right after DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic busy_ok;
    logic [31:0] res;
    @(negedge clk);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 0; busy_ok = 1'b1; res = '0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (busy_o !== 1'b1) busy_ok = 1'b0;
      if (valid_o === 1'b1) begin lat = c; res = result_o; break; end
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, res, exp);
    check({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, {31'b0, valid_o}, 32'd0);
    check({tag, "_idle"}, {31'b0, busy_o}, 32'd0);
    check({tag, "_hold"}, result_o, exp);
  endtask

  initial begin
    int lat;
    int nvalid;
    logic [31:0] res;
    logic bad;

    rst_n = 1'b0; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Signed/unsigned on the same operands
    run_op("div_neg7_2",  DIV_OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT_FULL);
    run_op("rem_neg7_2",  DIV_OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, LAT_FULL);
    run_op("divu_big_2",  DIV_OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, LAT_FULL);
    run_op("remu_big_2",  DIV_OP_REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001, LAT_FULL);
    run_op("div_7_neg2",  DIV_OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, LAT_FULL);
    run_op("rem_7_neg2",  DIV_OP_REM,  32'd7, 32'hFFFFFFFE, 32'h00000001, LAT_FULL);
    run_op("divu_max_1",  DIV_OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, LAT_FULL);

    // Divide by zero
    run_op("divu_by0", DIV_OP_DIVU, 32'h00001234, 32'd0, 32'hFFFFFFFF, LAT_SP);
    run_op("div_by0",  DIV_OP_DIV,  32'h00001234, 32'd0, 32'hFFFFFFFF, LAT_SP);
    run_op("rem_by0",  DIV_OP_REM,  32'h00001234, 32'd0, 32'h00001234, LAT_SP);
    run_op("remu_by0", DIV_OP_REMU, 32'h00001234, 32'd0, 32'h00001234, LAT_SP);

    // Signed overflow
    run_op("div_ovf", DIV_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SP);
    run_op("rem_ovf", DIV_OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_SP);

    // |a| < |b|
    run_op("divu_small", DIV_OP_DIVU, 32'd3, 32'd10, 32'd0, LAT_SP);
    run_op("rem_small",  DIV_OP_REM,  32'hFFFFFFFD, 32'd10, 32'hFFFFFFFD, LAT_SP);

    // Start during an active operation is dropped
    @(negedge clk);
    start_i = 1'b1; op_i = DIV_OP_DIVU; a_i = 32'd50; b_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 2; c <= 10; c++) begin @(posedge clk); #1; end
    start_i = 1'b1; op_i = DIV_OP_DIVU; a_i = 32'd100; b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 0; nvalid = 0; res = '0;
    for (int c = 11; c <= 60; c++) begin
      if (valid_o === 1'b1) begin
        nvalid++;
        if (lat == 0) begin lat = c; res = result_o; end
      end
      @(posedge clk); #1;
    end
    check("busy_start_nvalid", nvalid, 32'd1);
    check("busy_start_lat", lat, LAT_FULL);
    check("busy_start_res", res, 32'd7);

    // Reset in the middle of an operation
    @(negedge clk);
    start_i = 1'b1; op_i = DIV_OP_DIV; a_i = 32'hFFFFFFF9; b_i = 32'd2;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 2; c <= 15; c++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", {31'b0, busy_o}, 32'd0);
    check("midrst_valid", {31'b0, valid_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
    end
    check("midrst_quiet", {31'b0, bad}, 32'd0);
    run_op("divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
